// File: rtl/datapath_scheduler_pkg.sv
// Shared widths, screen defaults, opcodes and instruction field offsets for the
// Datapath scheduler and its raster counter.
package datapath_scheduler_pkg;
   localparam int DFLT_SCREEN_WIDTH  = 160;
   localparam int DFLT_SCREEN_HEIGHT = 120;
   localparam int INSTRUCTION_WIDTH  = 32;
   localparam int OPCODE_WIDTH       = 4;
   localparam int RESULT_WIDTH       = 12;
   localparam int X_COORD_WIDTH      = 8;
   localparam int Y_COORD_WIDTH      = 7;
   localparam int COLOUR_WIDTH       = 3;

   localparam int OPCODE_LSB = INSTRUCTION_WIDTH - OPCODE_WIDTH;
   localparam int INSTR_X_LSB = 0;
   localparam int INSTR_Y_LSB = 8;

   localparam logic [OPCODE_WIDTH-1:0] OPCODE_DISPLAY = 4'd3;

   typedef enum logic {
      OWNER_HOST = 1'b0,
      OWNER_SCAN = 1'b1
   } owner_e;

   typedef struct packed {
      logic [X_COORD_WIDTH-1:0] x;
      logic [Y_COORD_WIDTH-1:0] y;
      logic [COLOUR_WIDTH-1:0]  colour;
   } pixel_t;

   // Framebuffer read-out instruction for one pixel; unused bits stay zero.
   function automatic logic [INSTRUCTION_WIDTH-1:0] display_instr(
      input logic [X_COORD_WIDTH-1:0] x,
      input logic [Y_COORD_WIDTH-1:0] y
   );
      logic [INSTRUCTION_WIDTH-1:0] instr;
      instr = '0;
      instr[OPCODE_LSB +: OPCODE_WIDTH]     = OPCODE_DISPLAY;
      instr[INSTR_Y_LSB +: Y_COORD_WIDTH]   = y;
      instr[INSTR_X_LSB +: X_COORD_WIDTH]   = x;
      return instr;
   endfunction
endpackage

// File: rtl/datapath_scheduler_raster_counter.sv
// Raster-scan x/y position: steps one pixel per advance, wraps at the screen
// edges and flags the last pixel of the frame.
module raster_counter
   import datapath_scheduler_pkg::*;
#(
   parameter int WIDTH  = DFLT_SCREEN_WIDTH,
   parameter int HEIGHT = DFLT_SCREEN_HEIGHT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     advance,
   output logic [X_COORD_WIDTH-1:0] x,
   output logic [Y_COORD_WIDTH-1:0] y,
   output logic                     frame_done
);
   logic [X_COORD_WIDTH-1:0] x_q, x_d;
   logic [Y_COORD_WIDTH-1:0] y_q, y_d;
   logic x_last, y_last;

   assign x_last = (x_q == X_COORD_WIDTH'(WIDTH - 1));
   assign y_last = (y_q == Y_COORD_WIDTH'(HEIGHT - 1));

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (advance) begin
         if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign frame_done = advance && x_last && y_last;
endmodule

// File: rtl/datapath_scheduler.sv
// Sole issuer to the Datapath: round-robins host requests against per-pixel
// framebuffer read-outs and turns DISPLAY completions into VGA plot strobes.
module datapath_scheduler
   import datapath_scheduler_pkg::*;
#(
   parameter int SCREEN_WIDTH  = DFLT_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DFLT_SCREEN_HEIGHT
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         scan_enable,
   input  logic                         host_req,
   input  logic [INSTRUCTION_WIDTH-1:0] host_instr,
   output logic                         host_grant,
   output logic                         host_done,
   output logic [RESULT_WIDTH-1:0]      host_result,
   output logic                         dp_start,
   output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
   input  logic                         dp_finished,
   input  logic [RESULT_WIDTH-1:0]      dp_result,
   input  logic [X_COORD_WIDTH-1:0]     dp_x,
   input  logic [Y_COORD_WIDTH-1:0]     dp_y,
   input  logic [COLOUR_WIDTH-1:0]      dp_colour,
   output logic [X_COORD_WIDTH-1:0]     vga_x,
   output logic [Y_COORD_WIDTH-1:0]     vga_y,
   output logic [COLOUR_WIDTH-1:0]      vga_colour,
   output logic                         vga_plot,
   output logic                         frame_done
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]                   state_q, state_d;
   owner_e                       owner_q, owner_d;
   owner_e                       last_winner_q, last_winner_d;
   logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
   logic                         first_wait_q, first_wait_d;
   logic [RESULT_WIDTH-1:0]      result_q, result_d;
   pixel_t                       pixel_q, pixel_d;

   logic [X_COORD_WIDTH-1:0]     scan_x;
   logic [Y_COORD_WIDTH-1:0]     scan_y;
   logic                         scan_advance;
   logic                         scan_frame_done;
   logic                         grant_host;
   logic                         instr_is_display;

   assign instr_is_display = (instr_q[OPCODE_LSB +: OPCODE_WIDTH] == OPCODE_DISPLAY);

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_winner_d = last_winner_q;
      instr_d       = instr_q;
      first_wait_d  = 1'b0;
      result_d      = result_q;
      pixel_d       = pixel_q;
      grant_host    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dp_finished && (host_req || scan_enable)) begin
               // On a tie the requester that did not win last time goes first.
               grant_host    = host_req && (!scan_enable || last_winner_q == OWNER_SCAN);
               owner_d       = grant_host ? OWNER_HOST : OWNER_SCAN;
               last_winner_d = owner_d;
               instr_d       = grant_host ? host_instr : display_instr(scan_x, scan_y);
               state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            first_wait_d = 1'b1;
            state_d      = ST_WAIT;
         end
         ST_WAIT: begin
            // finished may still read high in the first cycle after start.
            if (!first_wait_q && dp_finished) begin
               if (owner_q == OWNER_HOST) result_d = dp_result;
               if (owner_q == OWNER_SCAN || instr_is_display) begin
                  pixel_d.x      = dp_x;
                  pixel_d.y      = dp_y;
                  pixel_d.colour = dp_colour;
               end
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         owner_q       <= OWNER_HOST;
         last_winner_q <= OWNER_SCAN;
         instr_q       <= '0;
         first_wait_q  <= 1'b0;
         result_q      <= '0;
         pixel_q       <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_winner_q <= last_winner_d;
         instr_q       <= instr_d;
         first_wait_q  <= first_wait_d;
         result_q      <= result_d;
         pixel_q       <= pixel_d;
      end
   end

   assign scan_advance = (state_q == ST_DONE) && (owner_q == OWNER_SCAN);

   raster_counter #(
      .WIDTH  (SCREEN_WIDTH),
      .HEIGHT (SCREEN_HEIGHT)
   ) u_raster (
      .clock      (clock),
      .reset      (reset),
      .advance    (scan_advance),
      .x          (scan_x),
      .y          (scan_y),
      .frame_done (scan_frame_done)
   );

   assign dp_start       = (state_q == ST_ISSUE);
   assign dp_instruction = instr_q;
   assign host_grant     = dp_start && (owner_q == OWNER_HOST);
   assign host_done      = (state_q == ST_DONE) && (owner_q == OWNER_HOST);
   assign host_result    = result_q;
   assign vga_plot       = (state_q == ST_DONE) && (owner_q == OWNER_SCAN || instr_is_display);
   assign vga_x          = pixel_q.x;
   assign vga_y          = pixel_q.y;
   assign vga_colour     = pixel_q.colour;
   assign frame_done     = scan_frame_done;
endmodule

// File: tb/tb_datapath_scheduler.sv
// Bench for datapath_scheduler: a behavioural Datapath, a transaction-level
// reference checked every cycle, and directed plus random request traffic.
module tb_datapath_scheduler;
   localparam int W = 160;
   localparam int H = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        scan_enable = 1'b0;
   logic        host_req = 1'b0;
   logic [31:0] host_instr = 32'h0;
   logic        host_grant, host_done, dp_start, vga_plot, frame_done;
   logic [11:0] host_result;
   logic [31:0] dp_instruction;
   logic        dp_finished;
   logic [11:0] dp_result;
   logic [7:0]  dp_x, vga_x;
   logic [6:0]  dp_y, vga_y;
   logic [2:0]  dp_colour, vga_colour;

   datapath_scheduler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
      .clock          (clock),
      .reset          (reset),
      .scan_enable    (scan_enable),
      .host_req       (host_req),
      .host_instr     (host_instr),
      .host_grant     (host_grant),
      .host_done      (host_done),
      .host_result    (host_result),
      .dp_start       (dp_start),
      .dp_instruction (dp_instruction),
      .dp_finished    (dp_finished),
      .dp_result      (dp_result),
      .dp_x           (dp_x),
      .dp_y           (dp_y),
      .dp_colour      (dp_colour),
      .vga_x          (vga_x),
      .vga_y          (vga_y),
      .vga_colour     (vga_colour),
      .vga_plot       (vga_plot),
      .frame_done     (frame_done)
   );

   always #5 clock = ~clock;

   // Datapath: random 1..3 cycle latency, sometimes drops finished a cycle late.
   logic [31:0] dp_cur;
   logic        dp_late;
   logic [1:0]  dp_cnt;
   always_ff @(posedge clock) begin
      if (reset) begin
         dp_finished <= 1'b1; dp_late <= 1'b0; dp_cnt <= 2'd0; dp_cur <= 32'h0;
         dp_result <= 12'h0; dp_x <= 8'h0; dp_y <= 7'h0; dp_colour <= 3'h0;
      end else if (dp_start) begin
         dp_cur <= dp_instruction;
         dp_cnt <= 2'($urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) dp_late <= 1'b1;
         else dp_finished <= 1'b0;
      end else if (dp_late) begin
         dp_late <= 1'b0;
         dp_finished <= 1'b0;
      end else if (!dp_finished) begin
         if (dp_cnt <= 2'd1) begin
            dp_finished <= 1'b1;
            dp_result   <= dp_cur[11:0] ^ 12'hAAC;
            dp_x        <= dp_cur[7:0];
            dp_y        <= dp_cur[14:8];
            dp_colour   <= dp_cur[2:0] ^ dp_cur[10:8];
         end else begin
            dp_cnt <= dp_cnt - 2'd1;
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[31:28] = 4'd3;
      return r;
   endfunction

   // Reference: one transaction at a time, sized by elapsed cycles since grant.
   bit          m_busy = 0, m_host = 0, m_last_host = 0, m_in_done = 0;
   int          m_age = 0, m_px = 0, m_py = 0;
   logic [31:0] m_instr = 32'h0;
   logic [11:0] m_hres = 12'h0;
   bit          e_start = 0, e_grant = 0, e_done = 0, e_plot = 0, e_frame = 0, e_rst = 0;
   logic [7:0]  e_x = 8'h0;
   logic [6:0]  e_y = 7'h0;
   logic [2:0]  e_c = 3'h0;

   initial begin
      forever begin
         @(posedge clock);
         e_start = 0; e_grant = 0; e_done = 0; e_plot = 0; e_frame = 0;
         if (reset) begin
            m_busy = 0; m_in_done = 0; m_last_host = 0; m_px = 0; m_py = 0;
            m_hres = 12'h0; m_instr = 32'h0; e_rst = 1;
         end else begin
            e_rst = 0;
            if (m_busy) begin
               if (m_in_done) begin
                  m_busy = 0; m_in_done = 0;
               end else begin
                  if (m_age >= 2 && dp_finished) begin
                     m_in_done = 1;
                     e_done = m_host;
                     e_plot = (m_instr[31:28] == 4'd3);
                     e_x = m_instr[7:0]; e_y = m_instr[14:8];
                     e_c = m_instr[2:0] ^ m_instr[10:8];
                     if (m_host) m_hres = m_instr[11:0] ^ 12'hAAC;
                     else begin
                        e_frame = (m_px == W - 1) && (m_py == H - 1);
                        m_px++;
                        if (m_px == W) begin m_px = 0; m_py = (m_py + 1) % H; end
                     end
                  end
                  m_age++;
               end
            end else if (dp_finished && (host_req || scan_enable)) begin
               m_host = host_req && (!scan_enable || !m_last_host);
               m_last_host = m_host; m_busy = 1; m_age = 0;
               m_instr = m_host ? host_instr : {4'd3, 13'd0, 7'(m_py), 8'(m_px)};
               e_start = 1; e_grant = m_host;
            end
         end
      end
   end

   logic [14:0] plot_q[$];
   bit          grant_q[$];
   int          frame_at = -1, n_hgrant = 0, n_hdone = 0;

   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (e_rst) begin
            chk("rst_dp_start", dp_start, 0);       chk("rst_host_grant", host_grant, 0);
            chk("rst_host_done", host_done, 0);     chk("rst_host_result", host_result, 0);
            chk("rst_dp_instruction", dp_instruction, 0);
            chk("rst_vga_plot", vga_plot, 0);       chk("rst_frame_done", frame_done, 0);
            chk("rst_vga_x", vga_x, 0); chk("rst_vga_y", vga_y, 0); chk("rst_vga_colour", vga_colour, 0);
         end else begin
            chk("dp_start", dp_start, e_start);
            chk("host_grant", host_grant, e_grant);
            chk("host_done", host_done, e_done);
            chk("vga_plot", vga_plot, e_plot);
            chk("frame_done", frame_done, e_frame);
            chk("host_result", host_result, m_hres);
            if (m_busy) chk("dp_instruction", dp_instruction, m_instr);
            if (e_plot) begin
               chk("vga_x", vga_x, e_x); chk("vga_y", vga_y, e_y); chk("vga_colour", vga_colour, e_c);
            end
         end
         if (vga_plot) plot_q.push_back({vga_x, vga_y});
         if (frame_done) frame_at = plot_q.size();
         if (dp_start) grant_q.push_back(host_grant);
         if (host_grant) n_hgrant++;
         if (host_done) n_hdone++;
      end
   end

   initial begin
      bit found;
      int n0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Single host MEMREAD
      host_instr = 32'h1000_0010; host_req = 1'b1;
      @(negedge clock);
      chk("A_start_latency", dp_start, 1);
      chk("A_grant_with_start", host_grant, 1);
      host_req = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (host_done) begin found = 1; chk("A_result", host_result, 12'hABC); end
      end
      chk("A_done_seen", found, 1);
      chk("A_no_plot", plot_q.size(), 0);

      // Scanner alone through a full frame
      scan_enable = 1'b1;
      for (int i = 0; i < 12000 && frame_at < 0; i++) @(negedge clock);
      chk("B_frame_seen", frame_at > 0, 1);
      chk("B_plot0", plot_q[0], {8'd0, 7'd0});
      chk("B_plot1", plot_q[1], {8'd1, 7'd0});
      chk("B_plot159", plot_q[159], {8'd159, 7'd0});
      chk("B_plot160", plot_q[160], {8'd0, 7'd1});
      chk("B_frame_count", frame_at, W * H);
      if (frame_at > 0) begin
         chk("B_frame_pixel", plot_q[frame_at - 1], {8'd159, 7'(H - 1)});
         for (int i = 0; i < 30 && plot_q.size() <= frame_at; i++) @(negedge clock);
         chk("B_wrap_to_origin", plot_q[frame_at], {8'd0, 7'd0});
      end
      scan_enable = 1'b0;
      repeat (20) @(negedge clock);

      // Both requesting continuously
      grant_q.delete();
      host_instr = rand_instr(); host_req = 1'b1; scan_enable = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (host_grant) host_instr = rand_instr();
      end
      chk("C_order0", grant_q[0], 1); chk("C_order1", grant_q[1], 0);
      chk("C_order2", grant_q[2], 1); chk("C_order3", grant_q[3], 0);
      host_req = 1'b0; scan_enable = 1'b0;
      repeat (20) @(negedge clock);

      // Host pulse while a scanner transaction is in flight
      scan_enable = 1'b1; found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clock);
         if (dp_start && !host_grant) found = 1;
      end
      chk("D_scan_started", found, 1);
      n0 = n_hgrant;
      host_instr = 32'h1000_0042; host_req = 1'b1;
      @(negedge clock);
      host_req = 1'b0;
      repeat (12) @(negedge clock);
      chk("D_no_host_grant", n_hgrant - n0, 0);
      scan_enable = 1'b0;
      repeat (20) @(negedge clock);

      // Reset during WAIT of a host MEMWRITE
      host_instr = 32'h2000_0123; host_req = 1'b1; found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clock);
         if (host_grant) found = 1;
      end
      chk("E_granted", found, 1);
      host_req = 1'b0; n0 = n_hdone;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      grant_q.delete();
      host_instr = 32'h1000_0077; host_req = 1'b1; scan_enable = 1'b1;
      for (int i = 0; i < 10 && grant_q.size() == 0; i++) @(negedge clock);
      chk("E_no_done", n_hdone - n0, 0);
      chk("E_first_grant_host", grant_q.size() > 0 ? grant_q[0] : 1'b0, 1);

      // Random traffic with withdrawals, scan toggling and occasional reset
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock);
         reset = ($urandom_range(0, 499) == 0);
         if (host_req && host_grant) begin
            host_req = 1'($urandom_range(0, 1)); host_instr = rand_instr();
         end else if (host_req && $urandom_range(0, 15) == 0) begin
            host_req = 1'b0;
         end else if (!host_req && $urandom_range(0, 3) == 0) begin
            host_req = 1'b1; host_instr = rand_instr();
         end
         if ($urandom_range(0, 31) == 0) scan_enable = !scan_enable;
      end
      reset = 1'b0; host_req = 1'b0; scan_enable = 1'b0;
      repeat (20) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/datapath_scheduler.md
Name: datapath_scheduler

Overview:
- Sole issuer of instructions to the neuroevolution Datapath (start/instruction/finished handshake).
- Time-shares the Datapath between two requesters:
  - the host engine: network evaluation and mutation MEMREAD/MEMWRITE/DRAW;
  - an internal raster scanner that issues one DISPLAY per pixel to stream the framebuffer to the VGA adapter.
- Generates the VGA plot strobe, which the Datapath does not drive.

Parameters:
SCREEN_WIDTH, 160, pixels per row; scanner x wraps at SCREEN_WIDTH-1
SCREEN_HEIGHT, 120, rows; scanner y wraps at SCREEN_HEIGHT-1
INSTRUCTION_WIDTH, 32, Datapath instruction width; opcode in top OPCODE_WIDTH bits
OPCODE_WIDTH, 4, opcode field width
OPCODE_DISPLAY, 4'd3, opcode value for framebuffer read-out
RESULT_WIDTH, 12, Datapath result width
X_COORD_WIDTH, 8, x width; Y_COORD_WIDTH, 7, y width; COLOUR_WIDTH, 3, colour width

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
scan_enable  in  1  level; allows scanner requests
host_req  in  1  level; host_instr valid and held until host_grant
host_instr  in  INSTRUCTION_WIDTH  host instruction
host_grant  out  1  1-cycle pulse; host instruction issued, host may change host_instr
host_done  out  1  1-cycle pulse; host instruction complete, host_result valid this cycle
host_result  out  RESULT_WIDTH  Datapath result captured at completion; held until next host_done
dp_start  out  1  Datapath start, 1-cycle pulse
dp_instruction  out  INSTRUCTION_WIDTH  instruction presented with dp_start
dp_finished  in  1  Datapath idle/complete flag
dp_result  in  RESULT_WIDTH  Datapath result
dp_x  in  X_COORD_WIDTH  Datapath x output
dp_y  in  Y_COORD_WIDTH  Datapath y output
dp_colour  in  COLOUR_WIDTH  Datapath colour output
vga_x  out  X_COORD_WIDTH  plot x
vga_y  out  Y_COORD_WIDTH  plot y
vga_colour  out  COLOUR_WIDTH  plot colour
vga_plot  out  1  1-cycle pulse; pixel valid
frame_done  out  1  1-cycle pulse after pixel (SCREEN_WIDTH-1, SCREEN_HEIGHT-1) is plotted

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE; scanner x=0, y=0;
  - last_winner = SCAN, so the host wins the first tie.
- Reset mid-operation: instruction in flight is abandoned, no done/plot pulse is emitted. The Datapath shares the reset line.
- IDLE:
  - Requests considered only when dp_finished=1.
  - Candidates: host (host_req) and scanner (scan_enable).
  - If both request, grant the one that is not last_winner (round-robin). If one requests, grant it.
  - On grant: go to ISSUE, latch owner, drive dp_instruction.
  - Scanner instruction: opcode=OPCODE_DISPLAY, [14:8]=y, [7:0]=x, all other bits 0.
- ISSUE (1 cycle):
  - dp_start=1; dp_instruction held.
  - host_grant=1 if the owner is the host.
  - Go to WAIT.
- WAIT:
  - First WAIT cycle ignores dp_finished (Datapath drops finished on the edge that samples start). Afterward, dp_finished=1 means complete → DONE.
  - dp_instruction held stable throughout.
- DONE (1 cycle):
  - Host owner: host_result=dp_result, host_done=1.
  - Scanner owner:
    - vga_x=dp_x, vga_y=dp_y, vga_colour=dp_colour, vga_plot=1;
    - advance x, wrapping to 0 after SCREEN_WIDTH-1 and incrementing y;
    - y wraps to 0 after SCREEN_HEIGHT-1, with frame_done=1 in the same cycle as that plot.
  - Go to IDLE. Minimum transaction: IDLE→ISSUE→WAIT(≥2)→DONE = 5 cycles.
- A host instruction with opcode DISPLAY also produces a vga_plot pulse; scanner position is unaffected.
- host_req deasserted before grant: request withdrawn, no pulses.
- scan_enable dropped mid-transaction: the current pixel completes; the scanner holds position and resumes there.
- Fairness: with both requesting continuously, grants alternate host/scan.

Decomposition:
- Shared constants header: widths, SCREEN_*, opcode values, instruction field offsets (x [7:0], y [14:8]).
- One natural sub-module, raster_counter: x/y counter with advance input, wrap, and frame_done output.

Test Plan:
- Only host_req with MEMREAD 0x0010, Datapath returns 12'hABC → dp_start 1 cycle after request, host_grant with dp_start, host_done with host_result=12'hABC; no vga_plot.
- scan_enable=1, host idle, Datapath echoes colour 3'b101 → plots (0,0),(1,0)…(159,0),(0,1); vga_plot once per transaction.
- Full frame: 19200 plots, then frame_done coincident with plot (159,119); next plot is (0,0).
- host_req and scan_enable held high → grant order host, scan, host, scan; pixel stream contiguous, no pixel skipped.
- Reset asserted during WAIT of a host MEMWRITE → next cycle all outputs 0, no host_done; after release, first grant goes to host.
- host_req dropped for 1 cycle while a scanner transaction is in flight → no host_grant; scanner continues normally.
